// File: rtl/clock_divider_prog.sv
// clock_divider_prog: runtime-programmable clock divider with load/ack divisor reload and run/stop.
// Optional single-period step mode is compiled in when CLKDIV_STEP_EN is defined.
//
// state | meaning
// STOP  | idle; counter held at 0, out_clock/out_tick low
// RUN   | free-running divide-by-div_q
// STEP  | exactly one divided period, then back to STOP (CLKDIV_STEP_EN only)

module clock_divider_prog #(
  parameter int WIDTH       = 28,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             in_clock,
  input  logic             in_reset_n,
  input  logic             in_enable,
`ifdef CLKDIV_STEP_EN
  input  logic             in_step,
`endif
  input  logic [WIDTH-1:0] in_div_value,
  input  logic             in_div_load,
  output logic             out_div_ack,
  output logic             out_clock,
  output logic             out_tick,
  output logic             out_busy
);

  typedef enum logic [1:0] {
    STOP = 2'd0,
`ifdef CLKDIV_STEP_EN
    STEP = 2'd2,
`endif
    RUN  = 2'd1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             pend_valid_q, pend_valid_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             last;
  logic             counting;
  logic [WIDTH-1:0] half;
`ifdef CLKDIV_STEP_EN
  logic             step_q, step_d;
  logic             step_rise;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_d        = div_q;
    pend_div_d   = pend_div_q;
    pend_valid_d = pend_valid_q;
    clk_d        = 1'b0;
    tick_d       = 1'b0;
    ack_d        = 1'b0;
    counting     = 1'b0;
    last         = (cnt_q == (div_q - WIDTH'(1)));
    half         = div_q >> 1;
`ifdef CLKDIV_STEP_EN
    step_d       = in_step;
    step_rise    = in_step & ~step_q;
`endif

    case (state_q)
      STOP: begin
        if (in_enable) begin
          state_d  = RUN;
          counting = 1'b1;
        end
`ifdef CLKDIV_STEP_EN
        else if (step_rise) begin
          state_d  = STEP;
          counting = 1'b1;
        end
`endif
      end
      RUN: begin
        if (in_enable) begin
          counting = 1'b1;
        end else begin
          state_d = STOP;
          cnt_d   = '0;
        end
      end
`ifdef CLKDIV_STEP_EN
      STEP: begin
        counting = 1'b1;
        if (in_enable) state_d = RUN;
        else if (last) state_d = STOP;
      end
`endif
      default: begin
        state_d = STOP;
        cnt_d   = '0;
      end
    endcase

    if (counting) begin
      clk_d  = (cnt_q < half);
      tick_d = last;
      cnt_d  = last ? '0 : (cnt_q + WIDTH'(1));
    end

    // Apply only a value that was already pending before this edge; a load on
    // this same edge is captured below and waits for the next boundary.
    if (pend_valid_q && ((state_q == STOP) || (counting && last))) begin
      div_d        = pend_div_q;
      pend_valid_d = 1'b0;
      ack_d        = 1'b1;
    end

    if (in_div_load) begin
      pend_div_d   = (in_div_value < WIDTH'(2)) ? WIDTH'(2) : in_div_value;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q      <= STOP;
      cnt_q        <= '0;
      div_q        <= WIDTH'(DEFAULT_DIV);
      pend_div_q   <= '0;
      pend_valid_q <= 1'b0;
      clk_q        <= 1'b0;
      tick_q       <= 1'b0;
      ack_q        <= 1'b0;
`ifdef CLKDIV_STEP_EN
      step_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      pend_div_q   <= pend_div_d;
      pend_valid_q <= pend_valid_d;
      clk_q        <= clk_d;
      tick_q       <= tick_d;
      ack_q        <= ack_d;
`ifdef CLKDIV_STEP_EN
      step_q       <= step_d;
`endif
    end
  end

  assign out_clock   = clk_q;
  assign out_tick    = tick_q;
  assign out_div_ack = ack_q;
  assign out_busy    = pend_valid_q;

endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
Runtime-programmable clock divider producing a divided clock and a one-cycle period tick from the system clock. It generalises the fixed-divisor divider with:
- parametrised counter width and default divisor
- glitch-free divisor reload over a load/ack handshake
- run/stop control

It sits between the board clock and the CPU/datapath, driving out_clock (slow clock) and out_tick (clock enable) into the Mini-SRC system.

Parameters:
WIDTH, 28, width of divisor and internal counter
DEFAULT_DIV, 5, divisor loaded at reset (must be >= 2 and < 2^WIDTH)

Ports:
in_clock  input  1  system clock; all logic on rising edge
in_reset_n  input  1  asynchronous, active-low reset
in_enable  input  1  1 = run, 0 = stop
in_div_value  input  WIDTH  new divisor D
in_div_load  input  1  one-cycle strobe; capture in_div_value
out_div_ack  output  1  one-cycle pulse when the new divisor takes effect
out_clock  output  1  divided clock
out_tick  output  1  one-cycle pulse, once per divided period
out_busy  output  1  high while a captured divisor is pending

Behaviour:
- Reset (in_reset_n=0, asynchronous):
  - counter=0, div_reg=DEFAULT_DIV, pend_valid=0
  - out_clock=0, out_tick=0, out_div_ack=0, out_busy=0
  - state=STOP
- States:
  - STOP (in_enable=0): counter held at 0; out_clock=0; out_tick=0.
  - RUN (in_enable=1).
  - STOP->RUN on the first edge with in_enable=1; counting starts at 0 on that edge.
  - RUN->STOP on any edge with in_enable=0; counter cleared immediately, mid-period allowed, no tick.
- RUN counting, with D=div_reg:
  - counter increments each edge and wraps D-1 -> 0.
  - out_clock registered: out_clock <= (counter < D/2). Integer division, so high floor(D/2) cycles, low ceil(D/2) cycles.
  - out_tick <= (counter == D-1), i.e. exactly one cycle per D cycles.
  - Both outputs lag the counter by 1 cycle.
- Divisor clamping: values 0 and 1 are clamped to 2 at capture. No other arithmetic saturation; all counter compares are WIDTH bits.
- Load handshake:
  - in_div_load=1 captures the clamped in_div_value into pend_div and sets pend_valid; out_busy=pend_valid.
  - In RUN: the pending value is applied on the period boundary, i.e. the edge where counter==D-1 and pend_valid was already set before that edge. On that edge: div_reg<=pend_div, counter<=0, pend_valid<=0, out_div_ack<=1 for one cycle. No partial or glitched period.
  - In STOP: the pending value is applied on the next edge, with ack on the same terms.
  - Load on the same edge as a boundary: captured, but applied at the following boundary.
  - Load while pending: overwrites pend_div, no extra ack; exactly one ack per application.
- Reset mid-period or mid-handshake discards the pending value; no ack.
- Simultaneous in_enable fall and boundary: STOP wins. The pending value is applied on the next edge via the STOP rule.

Optional Feature:
Macro CLKDIV_STEP_EN.
- Defined:
  - Adds input in_step (1 bit) and internal state STEP.
  - In STOP, a rising edge of in_step (registered edge detect, 1-cycle delay) enters STEP.
  - STEP runs exactly one full period (D cycles, one out_tick), then returns to STOP.
  - in_enable=1 during STEP moves to RUN without restarting the counter.
  - Further in_step edges during STEP are ignored.
  - Pending loads apply at the STEP period boundary.
- Undefined: no in_step port; STOP exits only via in_enable.

Test Plan:
- Reset default: DEFAULT_DIV=5, enable=1 after reset release -> out_clock pattern 1,1,0,0,0 repeating; out_tick once every 5 cycles; ack=0, busy=0.
- Mid-period reload: load 8 at counter=2 -> busy=1 until boundary; ack one cycle at boundary; next period 8 cycles (high 4, low 4); no short period.
- Clamp and odd divisor: load 0 -> D=2, out_clock toggles every cycle, tick every 2 cycles. Load 7 -> high 3, low 4.
- Double load: load 6 then 9 within one period -> single ack; applied divisor 9.
- Stop and reset: in_enable=0 at counter=3 -> next cycle out_clock=0, out_tick=0, counter=0, and restart begins a fresh period. Async in_reset_n pulse between clock edges with a load pending -> outputs 0 immediately; no ack after release; divisor back to 5.
- Step (CLKDIV_STEP_EN, D=4, in STOP): pulse in_step -> exactly 4 cycles of 1,1,0,0 and one tick, then idle. A second in_step pulse inside the period is ignored.
